// File: rtl/zap_dram_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : zap_dram_responder_pkg
//  Purpose  : Shared definitions for the data-memory responder: the access
//             state encoding (IDLE/WAIT/DONE), the Galois LFSR tap constant
//             and the LFSR step function.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package zap_dram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

    // One step of a right-shifting Galois LFSR: the bit shifted out selects
    // whether the tap pattern is folded back in.
    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        lfsr_next = value[0] ? ((value >> 1) ^ C_LFSR_TAPS) : (value >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/zap_lfsr16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : zap_lfsr16
//  Purpose  : 16-bit Galois LFSR, advancing one step per enabled cycle.
//  Ports    : i_clk    - clock
//             i_reset  - synchronous active-high reset (loads SEED)
//             i_en     - advance by one step at the next clock edge
//             o_value  - current LFSR state
//  Revision : 1.0 - initial release
// ============================================================================
module zap_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    output logic [15:0] o_value
);
    import zap_dram_responder_pkg::*;

    logic [15:0] r_value_q;

    // An all-zero state would lock the LFSR up permanently.
    if (SEED == 16'h0000) begin : g_bad_seed
        $fatal(1, "zap_lfsr16: SEED must be non-zero");
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_value_q <= SEED;
        end else if (i_en) begin
            r_value_q <= lfsr_next(r_value_q);
        end
    end

    assign o_value = r_value_q;

endmodule
`default_nettype wire

// File: rtl/zap_dram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : zap_dram_responder
//  Purpose  : Far end of the core's simple data-memory interface. Each access
//             is held off with o_stall for WAIT_CYCLES (+0..3 random) wait
//             states, then completes as a byte-enabled write or a registered
//             read. Backed by an inferred RAM with four byte lanes.
//  Ports    : i_clk    - clock
//             i_reset  - synchronous active-high reset
//             i_wr_en  - write request (held until o_stall is seen low)
//             i_rd_en  - read request (held the same way)
//             i_addr   - byte address, word index taken from [IDX+1:2]
//             i_data   - write data
//             i_ben    - byte enables, bit n -> lane [8n+7:8n]
//             o_data   - registered read data
//             o_stall  - 1 while the presented request is not yet complete
//  Revision : 1.0 - initial release
// ============================================================================
module zap_dram_responder #(
    parameter int          DEPTH_WORDS   = 4096,
    parameter int          WAIT_CYCLES   = 2,
    parameter bit          RAND_STALL_EN = 1'b0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  logic        i_rd_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_ben,
    output logic [31:0] o_data,
    output logic        o_stall
);
    import zap_dram_responder_pkg::*;

    localparam int                C_IDX_W    = $clog2(DEPTH_WORDS);
    // Counter must hold WAIT_CYCLES + 3 without overflow.
    localparam int                C_CNT_W    = $clog2(WAIT_CYCLES + 4) + 1;
    localparam logic [C_CNT_W-1:0] C_WAIT_CNT = C_CNT_W'(WAIT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $fatal(1, "zap_dram_responder: WAIT_CYCLES must be at least 1");
    end

    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "zap_dram_responder: DEPTH_WORDS must be a power of two >= 2");
    end

    state_t               r_state_q;
    state_t               w_state_d;
    logic [C_CNT_W-1:0]   r_cnt_q;
    logic [C_CNT_W-1:0]   w_cnt_d;
    logic [C_IDX_W-1:0]   r_idx_q;
    logic [31:0]          r_wdata_q;
    logic [3:0]           r_ben_q;
    logic                 r_is_wr_q;
    logic [31:0]          r_data_q;

    logic                 w_req;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_stall;
    logic [15:0]          w_lfsr;
    logic [C_CNT_W-1:0]   w_extra;
    logic                 w_unused_bits;

    logic [3:0][7:0]      r_mem [DEPTH_WORDS];

    zap_lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (w_accept),
        .o_value (w_lfsr)
    );

    assign w_req   = i_wr_en | i_rd_en;
    assign w_extra = RAND_STALL_EN ? {{(C_CNT_W-2){1'b0}}, w_lfsr[1:0]} : '0;
    // Final wait cycle: the access is performed at the edge that ends it.
    assign w_last  = (r_state_q == ST_WAIT) && (r_cnt_q == C_CNT_ONE);

    // Address bits outside the word index and the upper LFSR bits are
    // intentionally ignored.
    assign w_unused_bits = ^{i_addr[31:C_IDX_W+2], i_addr[1:0], w_lfsr};

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_accept  = 1'b0;
        w_stall   = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                w_stall = w_req;
                if (w_req) begin
                    w_accept  = 1'b1;
                    w_cnt_d   = C_WAIT_CNT + w_extra;
                    w_state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                w_cnt_d = r_cnt_q - C_CNT_ONE;
                if (r_cnt_q == C_CNT_ONE) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The core still presents the completed request here, so
                // inputs are deliberately not looked at.
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign o_stall = i_reset ? 1'b0 : w_stall;
    assign o_data  = r_data_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_wdata_q <= '0;
            r_ben_q   <= '0;
            r_is_wr_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            if (w_accept) begin
                r_idx_q   <= i_addr[C_IDX_W+1:2];
                r_wdata_q <= i_data;
                r_ben_q   <= i_ben;
                // Write wins when both enables are high.
                r_is_wr_q <= i_wr_en;
            end
            if (w_last && !r_is_wr_q) begin
                r_data_q <= r_mem[r_idx_q];
            end
        end
    end

    // RAM is never cleared; a reset in WAIT suppresses the pending write.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_last && r_is_wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (r_ben_q[b]) begin
                    r_mem[r_idx_q][b] <= r_wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zap_dram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_zap_dram_responder
//  Purpose  : Self-checking bench. Two responders (fixed and random stall)
//             are exercised one after the other; a reference model predicts
//             stall length and o_data per access into a queue that a monitor
//             drains whenever a stall ends.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zap_dram_responder;

    localparam int          DEPTH = 4096;
    localparam int          W     = 2;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef struct {
        int          dut;
        int          stall_len;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        wr    [2];
    logic        rd    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [3:0]  ben   [2];
    logic [31:0] rdata [2];
    logic        stall [2];

    exp_t        expq[$];
    int          run_len [2];
    int          n_chk  = 0;
    int          n_pass = 0;

    // Reference model state.
    logic [31:0] mm [int];
    logic [31:0] last_rd [2];
    bit          last_ok [2];
    logic [15:0] mlfsr   [2];

    always #5 clk = ~clk;

    zap_dram_responder #(
        .DEPTH_WORDS   (DEPTH),
        .WAIT_CYCLES   (W),
        .RAND_STALL_EN (1'b0),
        .LFSR_SEED     (SEED)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst[0]),
        .i_wr_en (wr[0]),
        .i_rd_en (rd[0]),
        .i_addr  (addr[0]),
        .i_data  (wdat[0]),
        .i_ben   (ben[0]),
        .o_data  (rdata[0]),
        .o_stall (stall[0])
    );

    zap_dram_responder #(
        .DEPTH_WORDS   (DEPTH),
        .WAIT_CYCLES   (W),
        .RAND_STALL_EN (1'b1),
        .LFSR_SEED     (SEED)
    ) u_dut_rnd (
        .i_clk   (clk),
        .i_reset (rst[1]),
        .i_wr_en (wr[1]),
        .i_rd_en (rd[1]),
        .i_addr  (addr[1]),
        .i_data  (wdat[1]),
        .i_ben   (ben[1]),
        .o_data  (rdata[1]),
        .o_stall (stall[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end else begin
            n_pass++;
        end
    endtask

    // Called at posedge+1: hold reset for the given cycles, checking outputs.
    task automatic do_reset(input int d, input int cycles);
        rst[d]     = 1'b1;
        mlfsr[d]   = SEED;
        last_rd[d] = 32'h0;
        last_ok[d] = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk($sformatf("dut%0d_reset_stall", d), {31'b0, stall[d]}, 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("dut%0d_reset_data", d), rdata[d], 32'h0);
        end
        rst[d] = 1'b0;
    endtask

    // Called at posedge+1. Predicts the outcome, presents the request, holds
    // it until stall drops, and releases it at the next posedge+1.
    task automatic issue(input int d, input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] dt, input logic [3:0] b);
        exp_t        e;
        int          key;
        int          extra;
        bit          done;
        logic [31:0] mask;
        key   = d * 65536 + int'((a >> 2) % DEPTH);
        extra = (d == 1) ? int'(mlfsr[d][1:0]) : 0;
        mlfsr[d] = (mlfsr[d] >> 1) ^ (mlfsr[d][0] ? 16'hB400 : 16'h0000);
        e.dut       = d;
        e.stall_len = W + extra + 1;
        if (w) begin
            mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
            if (mm.exists(key)) begin
                mm[key] = (mm[key] & ~mask) | (dt & mask);
            end else if (b == 4'hF) begin
                mm[key] = dt;
            end
        end else if (r) begin
            if (mm.exists(key)) begin
                last_rd[d] = mm[key];
                last_ok[d] = 1'b1;
            end else begin
                last_ok[d] = 1'b0;
            end
        end
        e.chk_data = last_ok[d];
        e.data     = last_rd[d];
        expq.push_back(e);

        wr[d] = w; rd[d] = r; addr[d] = a; wdat[d] = dt; ben[d] = b;
        done = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (!stall[d]) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_chk++;
            $display("FAIL dut%0d_timeout: stall still high after 24 cycles, expected release", d);
        end
        @(posedge clk);
        #1;
        wr[d] = 1'b0;
        rd[d] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr(input int max_word);
        logic [31:0] a;
        a = ($urandom_range(0, 3) << 14) | ($urandom_range(0, max_word) << 2) | $urandom_range(0, 3);
        return a;
    endfunction

    // Monitor: a completion is the first non-stalled cycle after a stall run.
    initial begin
        exp_t e;
        run_len[0] = 0;
        run_len[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) begin
                    run_len[d] = 0;
                end else if (stall[d]) begin
                    run_len[d]++;
                end else if (run_len[d] > 0) begin
                    if (expq.size() == 0) begin
                        n_chk++;
                        $display("FAIL dut%0d_unexpected_completion: stall run %0d, expected none", d, run_len[d]);
                    end else begin
                        e = expq.pop_front();
                        chk($sformatf("dut%0d_owner", d), d, e.dut);
                        chk($sformatf("dut%0d_stall_len", d), run_len[d], e.stall_len);
                        if (e.chk_data) begin
                            chk($sformatf("dut%0d_rdata", d), rdata[d], e.data);
                        end
                    end
                    run_len[d] = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; wr[d] = 1'b0; rd[d] = 1'b0;
            addr[d] = '0; wdat[d] = '0; ben[d] = '0;
            mlfsr[d] = SEED; last_rd[d] = '0; last_ok[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        do_reset(1, 2);

        // Fixed-stall responder: reset with a read held, then directed cases.
        rd[0] = 1'b1;
        addr[0] = 32'h0;
        do_reset(0, 3);
        issue(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 4'h0);
        issue(0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEADBEEF, 4'hF);
        issue(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        issue(0, 1'b1, 1'b0, 32'h0000_0040, 32'h11223344, 4'hF);
        issue(0, 1'b1, 1'b0, 32'h0000_0040, 32'hAABBCCDD, 4'b0101);
        issue(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0);
        issue(0, 1'b1, 1'b0, 32'h0000_4000, 32'h5A5A5A5A, 4'hF);
        issue(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 4'h0);
        issue(0, 1'b0, 1'b1, 32'h0000_4003, 32'h0, 4'h0);
        issue(0, 1'b1, 1'b1, 32'h0000_0008, 32'h12345678, 4'hF);
        issue(0, 1'b0, 1'b1, 32'h0000_0008, 32'h0, 4'h0);
        issue(0, 1'b1, 1'b0, 32'h0000_0100, 32'hFFFFFFFF, 4'h0);
        issue(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        for (int i = 0; i < 30; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            issue(0, kind < 4 || kind == 9, kind >= 4, rand_addr(31), $urandom, 4'($urandom));
        end

        // Random-stall responder: seed known words, back-to-back reads, abort.
        for (int i = 0; i < 8; i++) begin
            issue(1, 1'b1, 1'b0, 32'(i * 4), $urandom, 4'hF);
        end
        issue(1, 1'b1, 1'b0, 32'h0000_0020, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 16; i++) begin
            issue(1, 1'b0, 1'b1, rand_addr(8), 32'h0, 4'h0);
        end
        wr[1] = 1'b1; addr[1] = 32'h0000_0020; wdat[1] = 32'h0BADBAD0; ben[1] = 4'hF;
        @(negedge clk);
        chk("dut1_abort_accept_stall", {31'b0, stall[1]}, 32'h1);
        @(posedge clk);
        #1;
        wr[1] = 1'b0;
        do_reset(1, 1);
        issue(1, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            issue(1, kind < 4 || kind == 9, kind >= 4, rand_addr(15), $urandom, 4'($urandom));
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", expq.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zap_dram_responder.md
Name: zap_dram_responder

Overview:
- Synthesizable memory responder for the core's simple data-memory interface: the far end of the wr_en/rd_en/addr/ben/data/stall protocol that the core top drives.
- Used as on-chip RAM in FPGA builds and as a timing-stressing memory model in simulation.
- Holds off each access with `o_stall` for a programmable number of wait states, then completes it: a byte-enabled write, or a read returned through a registered data output.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; power of two, at least 2.
- WAIT_CYCLES, 2: base wait states per access; must be at least 1.
- RAND_STALL_EN, 0: when 1, adds 0–3 extra wait states per access, taken from an LFSR.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- i_clk, input, 1: clock. One clock domain; reset is synchronous, active-high.
- i_reset, input, 1: synchronous active-high reset.
- i_wr_en, input, 1: write request, held by the core until stall is seen low.
- i_rd_en, input, 1: read request, held the same way.
- i_addr, input, 32: byte address.
- i_data, input, 32: write data.
- i_ben, input, 4: byte enables; bit n selects byte lane [8n+7:8n].
- o_data, output, 32: read data, registered.
- o_stall, output, 1: 1 means the request is not yet complete.

Behaviour:
- States: IDLE, WAIT, DONE. The encoding lives in the shared include.
- Reset:
  - State goes to IDLE; o_data, wait counter and latched request registers go to 0; LFSR goes to LFSR_SEED.
  - o_stall is forced to 0 while i_reset is high.
  - The memory array is not cleared.
  - Reset during WAIT aborts the access; a pending write is discarded.
- req = i_wr_en | i_rd_en. If both are high, the access is a write; the read is ignored and o_data is unchanged.
- Word index = i_addr[log2(DEPTH_WORDS)+1 : 2]. Bits [1:0] and all higher bits are ignored, so the address wraps modulo DEPTH_WORDS×4.
- IDLE:
  - o_stall = req, combinational.
  - On req: latch addr, data, ben and type. Load cnt = WAIT_CYCLES + (RAND_STALL_EN ? lfsr[1:0] : 0). Go to WAIT.
  - The LFSR advances once per accepted request, never otherwise.
- WAIT:
  - o_stall = 1. cnt decrements each cycle.
  - In the cycle cnt == 1, perform the access at the clock edge:
    - Write: update only the byte lanes whose ben bit is 1; ben = 0 is a legal no-op.
    - Read: o_data <= mem[index].
  - Then go to DONE.
- DONE:
  - o_stall = 0; o_data holds the read value. The core samples it in this cycle.
  - Inputs are ignored, because the core still presents the old request. Next state is IDLE.
- Latency: a request first seen in cycle T gets o_stall high in cycles T .. T+cnt and low in T+cnt+1 (DONE).
  - Minimum occupancy is WAIT_CYCLES+2 cycles per access.
  - A new request can be accepted in the cycle after DONE.
- o_data changes only on read completion or reset. Writes never disturb it.
- Inputs that change while in WAIT have no effect; the latched copies are used.
- A deassertion of req during WAIT, which is a protocol violation, does not cancel the access.
- Simulation-only assertions:
  - WAIT_CYCLES == 0 → $fatal.
  - DEPTH_WORDS not a power of two → $fatal.

Decomposition:
- Shared include zap_mem_defs.vh: state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and the LFSR tap constant 16'hB400.
- Sub-module zap_lfsr16: Galois LFSR with ports i_clk, i_reset, i_en, o_value[15:0]. The responder instantiates it and uses o_value[1:0].
- The memory array is inferred inside zap_dram_responder as a byte-lane-writable RAM, four 8-bit lanes.

Test Plan:
- Reset with i_rd_en held at 1 → o_stall = 0 and o_data = 0 during reset. After release, the read of 0x0 stalls for 3 cycles (W=2) and DONE follows on the 4th.
- Write 0xDEADBEEF to 0x100 with ben=4'hF, then read 0x100 → o_data = 0xDEADBEEF in the DONE cycle. o_stall pattern per access is 1,1,1,0.
- Write 0x11223344 with ben=4'hF to 0x40, then 0xAABBCCDD with ben=4'b0101 to 0x40, then read → 0x11BB33DD.
- DEPTH_WORDS=4096: write 0x5A5A5A5A to 0x4000, read 0x0 → 0x5A5A5A5A (wrap). Read 0x4003 → same word (low bits ignored).
- i_wr_en=1 and i_rd_en=1 together with data 0x12345678 at 0x8 → word written. o_data keeps its previous value.
- RAND_STALL_EN=1: issue 16 back-to-back reads → each stall length is between W+1 and W+4 cycles and matches a reference LFSR model. Assert reset in WAIT of a write → the memory word is unchanged and state returns to IDLE.
